// File: rtl/npc_pkg.sv
// Shared constants and types for the npc core front end.
package npc_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] BAD_INST         = 32'h0000_007F;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: imem request/response, redirect/halt control and the decode-side output.
interface ifu_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [31:0] fetch_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instruction, fetch_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instruction, fetch_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the fetched {pc, instruction} in a registered valid/ready output.
//
//   state  | meaning
//   S_REQ  | presenting a request at pc (or emitting BAD_INST when misaligned)
//   S_WAIT | request accepted, waiting for the single response
//   S_HOLD | output register valid, waiting for the next stage to take it
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned XLEN     = 32
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic misaligned;
    logic req_fire;
    logic out_fire;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign out_fire   = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_REQ;
            kill_q        <= 1'b0;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_pc_q      <= RESET_PC;
            out_inst_q    <= NOP_INST;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_inst_q    <= out_inst_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_inst_d    = out_inst_q;
        fetch_count_d = fetch_count_q;

        // A handshake in the redirect cycle still counts as delivered.
        if (out_fire) begin
            out_valid_d   = 1'b0;
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (bus.redirect_valid) begin
            pc_d        = bus.redirect_pc;
            out_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (misaligned) begin
                        out_pc_d    = pc_q;
                        out_inst_d  = BAD_INST;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            out_pc_d    = pc_q;
                            out_inst_d  = bus.imem_resp_data;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + XLEN'(4);
                            state_d     = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (out_fire) state_d = S_REQ;
                end
            endcase
        end
    end

    // Request is gated by rst so it reads 0 while reset is held.
    always_comb begin
        bus.imem_req_valid  = rst && (state_q == S_REQ) && !bus.halt && !misaligned;
        bus.imem_req_addr   = pc_q;
        bus.out_valid       = out_valid_q;
        bus.out_pc          = out_pc_q;
        bus.out_instruction = out_inst_q;
        bus.fetch_count     = fetch_count_q;
    end

    resp_only_when_waiting: assert property (
        @(posedge clk) disable iff (!rst) bus.imem_resp_valid |-> (state_q == S_WAIT)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: a stream-level model predicts the
// ordered {pc, instruction} deliveries, a separate monitor checks the output side.
`timescale 1ns/1ps
module tb_ifu_fetch;
    import npc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          N_CYCLES = 4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if bus ();

    ifu_fetch #(
        .RESET_PC (RST_PC),
        .XLEN     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    item_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_pc;
    logic [31:0] model_count;
    int          cycle = 0;
    int          last_pop_cycle = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return EBREAK_INST;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_pc"}, bus.out_pc, RST_PC);
        check({tag, "_out_inst"}, bus.out_instruction, NOP_INST);
        check({tag, "_fetch_count"}, bus.fetch_count, 32'd0);
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.halt            = 1'b0;
        bus.out_ready       = 1'b0;
    endtask

    // Output-side monitor: pops the scoreboard on every out handshake.
    initial begin : monitor
        item_t       it;
        logic        pv, pr, prd;
        logic [31:0] ppc, pin;
        pv = 1'b0; pr = 1'b0; prd = 1'b0; ppc = '0; pin = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pr && !prd) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_pc", bus.out_pc, ppc);
                check("hold_inst", bus.out_instruction, pin);
            end
            check("fetch_count", bus.fetch_count, model_count);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pc %08h inst %08h, expected no delivery (cycle %0d)",
                             bus.out_pc, bus.out_instruction, cycle);
                end else begin
                    it = exp_q.pop_front();
                    check("out_pc", bus.out_pc, it.pc);
                    check("out_inst", bus.out_instruction, it.inst);
                end
                model_count    = model_count + 32'd1;
                last_pop_cycle = cycle;
            end
            pv  = bus.out_valid;
            pr  = bus.out_ready;
            prd = bus.redirect_valid;
            ppc = bus.out_pc;
            pin = bus.out_instruction;
        end
    end

    // Stimulus, imem model and request-side bookkeeping.
    initial begin : stim
        logic        mem_busy;
        int          mem_cnt;
        logic [31:0] mem_addr;
        logic        req_fire;
        logic        rst_done;
        item_t       it;

        mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; rst_done = 1'b0;
        model_pc = RST_PC;
        model_count = '0;
        idle_inputs();

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;

        for (cycle = 0; cycle < N_CYCLES; cycle++) begin
            @(negedge clk);

            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(mem_addr);
                    mem_busy = 1'b0;
                end else begin
                    bus.imem_resp_valid = 1'b0;
                    bus.imem_resp_data  = $urandom;
                end
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = $urandom;
            end

            // Asynchronous reset while a request is still outstanding.
            if (!rst_done && cycle >= 2000 && mem_busy) begin
                rst_done = 1'b1;
                rst = 1'b0;
                idle_inputs();
                exp_q.delete();
                model_pc    = RST_PC;
                model_count = '0;
                mem_busy    = 1'b0;
                #1;
                check_reset_values("async_reset");
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                last_pop_cycle = cycle;
                continue;
            end

            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.out_ready      = (cycle < 8) ? 1'b0 : ($urandom_range(0, 9) < 7);
            if (cycle < 8)
                bus.halt = 1'b0;
            else if (bus.halt)
                bus.halt = ($urandom_range(0, 2) != 0);
            else
                bus.halt = ($urandom_range(0, 24) == 0);

            if (cycle >= 20 && $urandom_range(0, 24) == 0) begin
                bus.redirect_valid = 1'b1;
                if ($urandom_range(0, 15) == 0)
                    bus.redirect_pc = 32'hFFFF_FFF8;
                else
                    bus.redirect_pc = RST_PC + 32'($urandom_range(0, 255)) * 32'd4;
                if ($urandom_range(0, 3) == 0)
                    bus.redirect_pc = bus.redirect_pc + 32'($urandom_range(1, 3));
            end else begin
                bus.redirect_valid = 1'b0;
                bus.redirect_pc    = $urandom;
            end

            #2;
            req_fire = bus.imem_req_valid && bus.imem_req_ready;
            if (bus.halt)
                check("halt_blocks_req", 32'(bus.imem_req_valid), 32'd0);
            if (req_fire) begin
                check("req_addr", bus.imem_req_addr, model_pc);
                check("one_outstanding", 32'(mem_busy), 32'd0);
                mem_busy = 1'b1;
                mem_addr = bus.imem_req_addr;
                mem_cnt  = $urandom_range(1, 3);
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                model_pc = bus.redirect_pc;
            end else if (req_fire) begin
                it.pc   = model_pc;
                it.inst = mem_word(model_pc);
                exp_q.push_back(it);
                model_pc = model_pc + 32'd4;
            end
            // A misaligned PC keeps producing BAD_INST words until redirected.
            if (exp_q.size() == 0 && model_pc[1:0] != 2'b00) begin
                it.pc   = model_pc;
                it.inst = BAD_INST;
                exp_q.push_back(it);
            end

            if (cycle - last_pop_cycle > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL watchdog: got no delivery for %0d cycles, expected progress", cycle - last_pop_cycle);
                break;
            end
        end

        n_checks++;
        if (model_count == 0 || !rst_done) begin
            n_fail++;
            $display("FAIL activity: got %0d deliveries after reset test %0d, expected nonzero and 1",
                     model_count, rst_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
